// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup and EX-side training signals of the branch target buffer.
// The BTB is the slave; the pipeline that drives it is the master.
interface branch_target_buffer_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      PC_IF;
    logic [31:0]      PredictPC;
    logic             PredictF;
    logic             PredictPCValid;
    logic             br_E;
    logic             br_taken_E;
    logic [31:0]      PC_E;
    logic [31:0]      br_target_E;
    logic             PredictE;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output PC_IF, br_E, br_taken_E, PC_E, br_target_E, PredictE,
        input  PredictPC, PredictF, PredictPCValid, br_count, mispred_count
    );

    modport slave (
        input  PC_IF, br_E, br_taken_E, PC_E, br_target_E, PredictE,
        output PredictPC, PredictF, PredictPCValid, br_count, mispred_count
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Zero-latency lookup at IF, training from EX, plus branch/misprediction counters.
module branch_target_buffer #(
    parameter int IDX_W = 6,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_target_buffer_if.slave  bus
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;
    localparam logic [1:0] CNT_SNT = 2'b00;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];
    logic [CNT_W-1:0]   br_count_q;
    logic [CNT_W-1:0]   mispred_count_q;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             up_we;
    logic             valid_d;
    logic [TAG_W-1:0] tag_d;
    logic [31:0]      target_d;
    logic [1:0]       cnt_d;

    // Byte offset within the instruction word plays no part in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.PC_IF[1:0], bus.PC_E[1:0]};

    assign lk_idx = bus.PC_IF[IDX_W+1:2];
    assign lk_tag = bus.PC_IF[31:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign bus.PredictPCValid = lk_hit;
    assign bus.PredictF       = lk_hit & cnt_q[lk_idx][1];
    assign bus.PredictPC      = lk_hit ? target_q[lk_idx] : 32'h0;

    assign up_idx = bus.PC_E[IDX_W+1:2];
    assign up_tag = bus.PC_E[31:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        up_we    = 1'b0;
        valid_d  = valid_q[up_idx];
        tag_d    = tag_q[up_idx];
        target_d = target_q[up_idx];
        cnt_d    = cnt_q[up_idx];
        if (bus.br_E) begin
            if (up_hit) begin
                up_we = 1'b1;
                if (bus.br_taken_E) begin
                    cnt_d    = (cnt_q[up_idx] == CNT_ST) ? CNT_ST : cnt_q[up_idx] + 2'd1;
                    target_d = bus.br_target_E;
                end else begin
                    cnt_d    = (cnt_q[up_idx] == CNT_SNT) ? CNT_SNT : cnt_q[up_idx] - 2'd1;
                end
            end else if (bus.br_taken_E) begin
                // Taken miss allocates, evicting whatever aliased into this slot.
                up_we    = 1'b1;
                valid_d  = 1'b1;
                tag_d    = up_tag;
                target_d = bus.br_target_E;
                cnt_d    = CNT_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q         <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
        end else begin
            if (up_we) begin
                valid_q[up_idx]  <= valid_d;
                tag_q[up_idx]    <= tag_d;
                target_q[up_idx] <= target_d;
                cnt_q[up_idx]    <= cnt_d;
            end
            if (bus.br_E) begin
                br_count_q <= br_count_q + CNT_W'(1);
                if (bus.br_taken_E != bus.PredictE) begin
                    mispred_count_q <= mispred_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.br_count      = br_count_q;
    assign bus.mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: hand-derived directed cases, then
// randomized training/lookup traffic checked against a behavioural reference model.
module tb_branch_target_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_target_buffer_if bus ();

    branch_target_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        v;
        logic        f;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic        m_v   [64];
    logic [23:0] m_tag [64];
    logic [31:0] m_tgt [64];
    logic [1:0]  m_cnt [64];
    logic [31:0] m_br;
    logic [31:0] m_mp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_lookup(input logic v, input logic f, input logic [31:0] pc);
        exp_t e;
        e.v = v; e.f = f; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 2'b01;
        end
        m_br = '0; m_mp = '0;
    endtask

    function automatic exp_t model_lookup(input logic [31:0] pc);
        exp_t e;
        int   i;
        i    = int'(pc[7:2]);
        e.v  = m_v[i] && (m_tag[i] == pc[31:8]);
        e.f  = e.v && (m_cnt[i] >= 2'd2);
        e.pc = e.v ? m_tgt[i] : 32'h0;
        return e;
    endfunction

    task automatic model_update(input logic tk, input logic [31:0] pc, input logic [31:0] tgt,
                                input logic pe);
        int i;
        i = int'(pc[7:2]);
        m_br = m_br + 1;
        if (tk != pe) m_mp = m_mp + 1;
        if (m_v[i] && m_tag[i] == pc[31:8]) begin
            if (tk) begin
                if (m_cnt[i] != 2'd3) m_cnt[i] = m_cnt[i] + 2'd1;
                m_tgt[i] = tgt;
            end else if (m_cnt[i] != 2'd0) begin
                m_cnt[i] = m_cnt[i] - 2'd1;
            end
        end else if (tk) begin
            m_v[i] = 1'b1; m_tag[i] = pc[31:8]; m_tgt[i] = tgt; m_cnt[i] = 2'd2;
        end
    endtask

    // One clock: drive at posedge+1, compare at negedge, retrain model at posedge.
    task automatic cycle(input string tag, input logic [31:0] pif, input logic br,
                         input logic tk, input logic [31:0] pce, input logic [31:0] tgt,
                         input logic pe, input bit use_model);
        exp_t e;
        bus.PC_IF = pif; bus.br_E = br; bus.br_taken_E = tk;
        bus.PC_E = pce; bus.br_target_E = tgt; bus.PredictE = pe;
        if (use_model) sb.push_back(model_lookup(pif));
        @(negedge clk);
        chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(bus.PredictPCValid), 32'(e.v));
            chk({tag, "_predf"}, 32'(bus.PredictF), 32'(e.f));
            chk({tag, "_predpc"}, bus.PredictPC, e.pc);
        end
        @(posedge clk);
        if (br && rst_n) model_update(tk, pce, tgt, pe);
        #1;
        bus.br_E = 1'b0;
    endtask

    task automatic chk_counts(input string tag, input logic [31:0] bc, input logic [31:0] mc);
        chk({tag, "_br_count"}, bus.br_count, bc);
        chk({tag, "_mispred_count"}, bus.mispred_count, mc);
    endtask

    initial begin
        logic [31:0] pif, pce, tgt;
        model_reset();
        bus.PC_IF = 32'h100; bus.br_E = 1'b0; bus.br_taken_E = 1'b0;
        bus.PC_E = '0; bus.br_target_E = '0; bus.PredictE = 1'b0;

        // reset state
        #12;
        chk("rst_valid", 32'(bus.PredictPCValid), 32'd0);
        chk("rst_predf", 32'(bus.PredictF), 32'd0);
        chk("rst_predpc", bus.PredictPC, 32'h0);
        chk_counts("rst", 32'd0, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // first taken branch allocates with WT
        expect_lookup(1'b0, 1'b0, 32'h0);
        cycle("t2_upd", 32'h100, 1, 1, 32'h100, 32'h80, 0, 0);
        expect_lookup(1'b1, 1'b1, 32'h80);
        cycle("t2_look", 32'h100, 0, 0, 32'h0, 32'h0, 0, 0);
        chk_counts("t2", 32'd1, 32'd1);

        // decrement 10 -> 01 -> 00
        expect_lookup(1'b1, 1'b1, 32'h80);
        cycle("t3_nt1", 32'h100, 1, 0, 32'h100, 32'h0, 1, 0);
        expect_lookup(1'b1, 1'b0, 32'h80);
        cycle("t3_nt2", 32'h100, 1, 0, 32'h100, 32'h0, 0, 0);
        expect_lookup(1'b1, 1'b0, 32'h80);
        cycle("t3_look", 32'h100, 0, 0, 32'h0, 32'h0, 0, 0);
        chk_counts("t3", 32'd3, 32'd2);

        // saturate at 11, one not-taken back to 10, then retarget
        expect_lookup(1'b1, 1'b0, 32'h80);
        cycle("t4_tk1", 32'h100, 1, 1, 32'h100, 32'h80, 0, 0);
        expect_lookup(1'b1, 1'b0, 32'h80);
        cycle("t4_tk2", 32'h100, 1, 1, 32'h100, 32'h80, 0, 0);
        expect_lookup(1'b1, 1'b1, 32'h80);
        cycle("t4_tk3", 32'h100, 1, 1, 32'h100, 32'h80, 0, 0);
        expect_lookup(1'b1, 1'b1, 32'h80);
        cycle("t4_tk4", 32'h100, 1, 1, 32'h100, 32'h80, 0, 0);
        expect_lookup(1'b1, 1'b1, 32'h80);
        cycle("t4_nt", 32'h100, 1, 0, 32'h100, 32'h0, 1, 0);
        expect_lookup(1'b1, 1'b1, 32'h80);
        cycle("t4_wt", 32'h100, 1, 1, 32'h100, 32'h90, 1, 0);
        expect_lookup(1'b1, 1'b1, 32'h90);
        cycle("t4_look", 32'h100, 0, 0, 32'h0, 32'h0, 0, 0);
        chk_counts("t4", 32'd9, 32'd7);

        // aliasing at index 0
        expect_lookup(1'b1, 1'b1, 32'h90);
        cycle("t5_alloc", 32'h100, 1, 1, 32'h200, 32'h40, 0, 0);
        expect_lookup(1'b0, 1'b0, 32'h0);
        cycle("t5_old", 32'h100, 0, 0, 32'h0, 32'h0, 0, 0);
        expect_lookup(1'b1, 1'b1, 32'h40);
        cycle("t5_new", 32'h200, 0, 0, 32'h0, 32'h0, 0, 0);
        expect_lookup(1'b1, 1'b1, 32'h40);
        cycle("t5_ntmiss", 32'h200, 1, 0, 32'h300, 32'h77, 0, 0);
        expect_lookup(1'b1, 1'b1, 32'h40);
        cycle("t5_kept", 32'h200, 0, 0, 32'h0, 32'h0, 0, 0);
        expect_lookup(1'b0, 1'b0, 32'h0);
        cycle("t5_300", 32'h300, 0, 0, 32'h0, 32'h0, 0, 0);
        chk_counts("t5", 32'd11, 32'd8);

        // same-cycle update and lookup: no bypass
        expect_lookup(1'b1, 1'b1, 32'h40);
        cycle("t6_same", 32'h200, 1, 1, 32'h200, 32'h44, 1, 0);
        expect_lookup(1'b1, 1'b1, 32'h44);
        cycle("t6_next", 32'h200, 0, 0, 32'h0, 32'h0, 0, 0);
        expect_lookup(1'b0, 1'b0, 32'h0);
        cycle("t6_same100", 32'h100, 1, 1, 32'h100, 32'h100, 0, 0);
        expect_lookup(1'b1, 1'b1, 32'h100);
        cycle("t6_lsb", 32'h102, 0, 0, 32'h0, 32'h0, 0, 0);
        expect_lookup(1'b0, 1'b0, 32'h0);
        cycle("t6_idx1", 32'h104, 0, 0, 32'h0, 32'h0, 0, 0);
        chk_counts("t6", 32'd13, 32'd9);

        // asynchronous reset mid-update
        bus.PC_IF = 32'h100; bus.br_E = 1'b1; bus.br_taken_E = 1'b1;
        bus.PC_E = 32'h104; bus.br_target_E = 32'h55; bus.PredictE = 1'b0;
        #2;
        chk("pre_rst_valid", 32'(bus.PredictPCValid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.PredictPCValid), 32'd0);
        chk("arst_predf", 32'(bus.PredictF), 32'd0);
        chk("arst_predpc", bus.PredictPC, 32'h0);
        chk_counts("arst", 32'd0, 32'd0);
        model_reset();
        @(posedge clk); #1;
        bus.PC_IF = 32'h104;
        #1;
        chk("arst_upd_ignored", 32'(bus.PredictPCValid), 32'd0);
        #2;
        rst_n = 1'b1;
        bus.br_E = 1'b0;
        @(posedge clk); #1;
        expect_lookup(1'b0, 1'b0, 32'h0);
        cycle("post_rst_104", 32'h104, 0, 0, 32'h0, 32'h0, 0, 0);
        expect_lookup(1'b0, 1'b0, 32'h0);
        cycle("post_rst_100", 32'h100, 0, 0, 32'h0, 32'h0, 0, 0);
        chk_counts("post_rst", 32'd0, 32'd0);

        // randomized traffic over a few indices and aliasing tags
        for (int n = 0; n < 400; n++) begin
            pif = (32'($urandom_range(1, 3)) << 8) | (32'($urandom_range(0, 3)) << 2)
                  | 32'($urandom_range(0, 3));
            pce = (32'($urandom_range(1, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
            tgt = $urandom & 32'hffff_fffc;
            cycle("rnd", pif, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pce, tgt,
                  1'($urandom_range(0, 1)), 1);
        end
        chk_counts("rnd_end", m_br, m_mp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
